hardreg_rr_arbiter: RTL and testbench

- Shares one W-bit holding register, with asynchronous active-low clear, between NREQ requesters.
- Uses a registered round-robin arbiter with a req/gnt handshake.
- A soft-clear request can zero the register synchronously.
- Sits between several producer blocks and the single shared data register. Downstream logic reads q, owner and q_valid.

---
 rtl/hardreg_rr_arbiter.sv | 114 +++++++++++
 tb/tb_hardreg_rr_arbiter.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/hardreg_rr_arbiter.sv
// Shared W-bit holding register loaded by NREQ requesters through a registered
// round-robin arbiter; each grant is followed by a mandatory one-cycle gap.
module hardreg_rr_arbiter #(
  parameter int W    = 4,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              clrb,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] din,
  input  logic              clr_req,
  output logic [NREQ-1:0]   gnt,
  output logic [W-1:0]      q,
  output logic [IDW-1:0]    owner,
  output logic              q_valid
);

  typedef enum logic {IDLE, GAP} state_t;

  state_t          state, state_nxt;
  logic [IDW-1:0]  ptr, ptr_nxt;
  logic [NREQ-1:0] gnt_nxt;
  logic [W-1:0]    q_nxt;
  logic [IDW-1:0]  owner_nxt;
  logic            q_valid_nxt;

  logic            found_hi, found_any;
  logic [IDW-1:0]  win_hi, win_any, win;
  logic [W-1:0]    data_hi, data_any, win_data;

  // Two passes: the lowest request at or above ptr wins; if none, the lowest
  // request overall wins, which is the wrap-around case.
  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a variable unassigned and no latch is inferred.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    win_hi    = '0;
    win_any   = '0;
    data_hi   = '0;
    data_any  = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        found_any = 1'b1;
        win_any   = IDW'(i);
        data_any  = din[i*W +: W];
        if (i >= int'(ptr)) begin
          found_hi = 1'b1;
          win_hi   = IDW'(i);
          data_hi  = din[i*W +: W];
        end
      end
    end
    win      = found_hi ? win_hi  : win_any;
    win_data = found_hi ? data_hi : data_any;
  end

  always_comb begin
    state_nxt   = IDLE;
    ptr_nxt     = ptr;
    gnt_nxt     = '0;
    q_nxt       = q;
    owner_nxt   = owner;
    q_valid_nxt = q_valid;
    case (state)
      IDLE: begin
        if (clr_req) begin
          // Clear outranks a pending request; the request stays asserted and
          // is served on a later IDLE cycle.
          q_nxt       = '0;
          q_valid_nxt = 1'b0;
        end else if (found_any) begin
          q_nxt       = win_data;
          owner_nxt   = win;
          q_valid_nxt = 1'b1;
          gnt_nxt     = {{(NREQ-1){1'b0}}, 1'b1} << win;
          ptr_nxt     = (win == IDW'(NREQ - 1)) ? '0 : win + 1'b1;
          state_nxt   = GAP;
        end
      end
      GAP: begin
        if (clr_req) begin
          q_nxt       = '0;
          q_valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  // NOTE: all outputs are plain flops with async clear, so a reset mid-grant
  // drops gnt immediately and restarts the pointer at 0.
  always_ff @(posedge clk or negedge clrb) begin
    if (!clrb) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      q       <= '0;
      owner   <= '0;
      q_valid <= 1'b0;
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      q       <= q_nxt;
      owner   <= owner_nxt;
      q_valid <= q_valid_nxt;
    end
  end

endmodule

// File: tb/tb_hardreg_rr_arbiter.sv
// Scoreboard bench for hardreg_rr_arbiter: each driven cycle pushes the
// expected outputs, which are popped and compared one edge later.
module tb_hardreg_rr_arbiter;

  logic        clk;
  logic        clrb;
  logic [3:0]  req;
  logic [15:0] din;
  logic        clr_req;
  logic [3:0]  gnt;
  logic [3:0]  q;
  logic [1:0]  owner;
  logic        q_valid;

  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] q;
    logic [1:0] owner;
    logic       valid;
  } exp_t;

  exp_t       sb[$];
  int         n_checks = 0;
  int         n_pass   = 0;
  logic [3:0] prev_gnt = '0;

  hardreg_rr_arbiter #(.W(4), .NREQ(4), .IDW(2)) dut (
    .clk     (clk),
    .clrb    (clrb),
    .req     (req),
    .din     (din),
    .clr_req (clr_req),
    .gnt     (gnt),
    .q       (q),
    .owner   (owner),
    .q_valid (q_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  // Drive one cycle of stimulus, queue its expected result, compare after the edge.
  task automatic step(input logic [3:0] r, input logic [15:0] d, input logic c,
                      input logic [3:0] eg, input logic [3:0] eq, input logic [1:0] eo,
                      input logic ev, input string tag);
    exp_t e;
    req     = r;
    din     = d;
    clr_req = c;
    sb.push_back('{gnt: eg, q: eq, owner: eo, valid: ev});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check({tag, ".gnt"},     32'(gnt),     32'(e.gnt));
    check({tag, ".q"},       32'(q),       32'(e.q));
    check({tag, ".owner"},   32'(owner),   32'(e.owner));
    check({tag, ".q_valid"}, 32'(q_valid), 32'(e.valid));
    check({tag, ".onehot"},  32'($countones(gnt) > 1), 32'd0);
    check({tag, ".adjacent"}, 32'((|prev_gnt) && (|gnt)), 32'd0);
    prev_gnt = gnt;
  endtask

  initial begin
    clrb    = 1'b0;
    req     = '0;
    din     = '0;
    clr_req = 1'b0;

    // Reset held with everything requesting.
    for (int i = 0; i < 5; i++) step(4'hF, 16'hFFFF, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, "reset");
    clrb = 1'b1;
    step(4'h0, 16'h0000, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, "idle");

    // Single requester, then its gap cycle.
    step(4'b0100, 16'h0500, 1'b0, 4'b0100, 4'h5, 2'd2, 1'b1, "single");
    step(4'b0000, 16'h0500, 1'b0, 4'b0000, 4'h5, 2'd2, 1'b1, "single_gap");

    // Load q=3, then assert reset between edges.
    step(4'b1000, 16'h3000, 1'b0, 4'b1000, 4'h3, 2'd3, 1'b1, "load3");
    step(4'b0000, 16'h3000, 1'b0, 4'b0000, 4'h3, 2'd3, 1'b1, "load3_gap");
    #2 clrb = 1'b0;
    #1;
    check("async.q",       32'(q),       32'd0);
    check("async.q_valid", 32'(q_valid), 32'd0);
    check("async.owner",   32'(owner),   32'd0);
    prev_gnt = gnt;
    step(4'h0, 16'h0000, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, "async_hold");
    clrb = 1'b1;

    // Full round robin from ptr=0, gap after each grant.
    for (int k = 0; k < 4; k++) begin
      step(4'hF, 16'h4321, 1'b0, 4'(1 << k), 4'(k + 1), 2'(k), 1'b1, "rr");
      step(4'hF, 16'h4321, 1'b0, 4'h0,       4'(k + 1), 2'(k), 1'b1, "rr_gap");
    end

    // ptr wrapped to 0: 1001 grants 0 then 3.
    step(4'b1001, 16'h4321, 1'b0, 4'b0001, 4'h1, 2'd0, 1'b1, "wrap0");
    step(4'b1001, 16'h4321, 1'b0, 4'b0000, 4'h1, 2'd0, 1'b1, "wrap0_gap");
    step(4'b1001, 16'h4321, 1'b0, 4'b1000, 4'h4, 2'd3, 1'b1, "wrap3");
    step(4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h4, 2'd3, 1'b1, "wrap3_gap");
    // After a grant to 1, a lone request from 0 must wrap and win.
    step(4'b0010, 16'h4321, 1'b0, 4'b0010, 4'h2, 2'd1, 1'b1, "skip1");
    step(4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h2, 2'd1, 1'b1, "skip1_gap");
    step(4'b0001, 16'h4321, 1'b0, 4'b0001, 4'h1, 2'd0, 1'b1, "skip0");
    step(4'b0000, 16'h4321, 1'b0, 4'b0000, 4'h1, 2'd0, 1'b1, "skip0_gap");

    // Soft clear in IDLE beats a pending request; request served afterwards.
    step(4'b0010, 16'h0020, 1'b0, 4'b0010, 4'h2, 2'd1, 1'b1, "pre_clr");
    step(4'b0000, 16'h0020, 1'b0, 4'b0000, 4'h2, 2'd1, 1'b1, "pre_clr_gap");
    step(4'b0010, 16'h0020, 1'b1, 4'b0000, 4'h0, 2'd1, 1'b0, "clr_idle");
    step(4'b0010, 16'h0020, 1'b0, 4'b0010, 4'h2, 2'd1, 1'b1, "post_clr");
    // Soft clear during the gap.
    step(4'b0000, 16'h0020, 1'b1, 4'b0000, 4'h0, 2'd1, 1'b0, "clr_gap");

    // Reset during the gap after a grant to 2; ptr must restart at 0.
    step(4'b0100, 16'h0500, 1'b0, 4'b0100, 4'h5, 2'd2, 1'b1, "pre_rst");
    clrb = 1'b0;
    #1;
    check("midrst.gnt", 32'(gnt), 32'd0);
    check("midrst.q",   32'(q),   32'd0);
    prev_gnt = gnt;
    step(4'hF, 16'h4321, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, "midrst_hold");
    clrb = 1'b1;
    step(4'h0, 16'h4321, 1'b0, 4'h0, 4'h0, 2'd0, 1'b0, "midrst_release");
    step(4'hF, 16'h4321, 1'b0, 4'b0001, 4'h1, 2'd0, 1'b1, "midrst_first");
    step(4'h0, 16'h4321, 1'b0, 4'b0000, 4'h1, 2'd0, 1'b1, "midrst_gap");

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
